// File: rtl/rv32i_dmem_amo_responder.sv
// Data-memory responder for the RV32I core. It takes one load, store or
// AMOADD.W request at a time over a valid/ready channel and answers over a
// valid/ready response channel. The read-modify-write of AMOADD.W spans
// ACCESS and AMO_WB. No other request can slip in between, because the
// request channel stays closed until the response handshake completes.
//
// Handshake semantics: a transfer occurs on a rising clk edge where valid and
// ready are both high. A producer holds valid and payload stable until the
// transfer. This block raises req_ready only in IDLE, and holds rsp_valid,
// rsp_rdata and rsp_err stable in RESP until rsp_ready is seen.
module rv32i_dmem_amo_responder #(
    parameter int DEPTH = 256,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_op,
    input  logic [2:0]    req_funct3,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic [1:0]    dbg_state
);
    localparam int LW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, AMO_WB = 2'd2, RESP = 2'd3} state_t;

    state_t        state, state_d;
    logic [1:0]    op_q;
    logic [2:0]    f3_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_d;
    logic          err_d;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wd;
    logic [31:0]   mem [DEPTH];
    logic [LW-1:0] idx;
    logic [31:0]   word_rd;
    logic [31:0]   shifted;
    logic [31:0]   load_val;
    logic          f3_legal;
    logic          misalign;
    logic          out_of_range;
    logic          req_bad;

    assign req_ready = (state == IDLE) && !rst;
    assign rsp_valid = (state == RESP);
    assign dbg_state = state;

    assign idx     = addr_q[LW+1:2];
    assign word_rd = mem[idx];
    assign shifted = word_rd >> {addr_q[1:0], 3'b000};

    // Request legality and load-data extraction for the latched request.
    always_comb begin
        f3_legal = 1'b0;
        case (op_q)
            2'b00:   f3_legal = (f3_q == 3'b000) || (f3_q == 3'b001) || (f3_q == 3'b010) ||
                                (f3_q == 3'b100) || (f3_q == 3'b101);
            2'b01:   f3_legal = (f3_q == 3'b000) || (f3_q == 3'b001) || (f3_q == 3'b010);
            2'b10:   f3_legal = (f3_q == 3'b010);
            default: f3_legal = 1'b0;
        endcase
        misalign     = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
                       ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
        out_of_range = ((addr_q >> 2) >= AW'(DEPTH));
        req_bad      = !f3_legal || misalign || out_of_range;
        case (f3_q)
            3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_val = {24'd0, shifted[7:0]};
            3'b101:  load_val = {16'd0, shifted[15:0]};
            default: load_val = word_rd;
        endcase
    end

    // Next-state, response data and array write controls.
    always_comb begin
        state_d = state;
        rdata_d = rsp_rdata;
        err_d   = rsp_err;
        mem_we  = 1'b0;
        mem_be  = 4'b0000;
        mem_wd  = 32'd0;
        case (state)
            IDLE: begin
                if (req_valid) state_d = ACCESS;
            end
            ACCESS: begin
                state_d = RESP;
                rdata_d = 32'd0;
                if (req_bad) begin
                    err_d = 1'b1;
                end else if (op_q == 2'b00) begin
                    rdata_d = load_val;
                end else if (op_q == 2'b01) begin
                    mem_we = 1'b1;
                    case (f3_q[1:0])
                        2'b00: begin
                            mem_be = 4'b0001 << addr_q[1:0];
                            mem_wd = {4{wdata_q[7:0]}};
                        end
                        2'b01: begin
                            mem_be = addr_q[1] ? 4'b1100 : 4'b0011;
                            mem_wd = {2{wdata_q[15:0]}};
                        end
                        default: begin
                            mem_be = 4'b1111;
                            mem_wd = wdata_q;
                        end
                    endcase
                end else begin
                    rdata_d = word_rd;
                    state_d = AMO_WB;
                end
            end
            AMO_WB: begin
                mem_we  = 1'b1;
                mem_be  = 4'b1111;
                mem_wd  = rsp_rdata + wdata_q;
                state_d = RESP;
            end
            default: begin
                if (rsp_ready) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    // State, response registers and request capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_d;
            rsp_rdata <= rdata_d;
            rsp_err   <= err_d;
            if (state == IDLE && req_valid) begin
                op_q    <= req_op;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    // Byte-lane writes into the array; never while reset is asserted.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be[i]) mem[idx][8*i +: 8] <= mem_wd[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_rv32i_dmem_amo_responder.sv
// Bench for rv32i_dmem_amo_responder: directed scenarios plus a random
// load/store mix against a byte-array model, with expected responses
// queued when each request is issued.
module tb_rv32i_dmem_amo_responder;
    localparam int DEPTH = 256;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [2:0]    req_funct3;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [1:0]    dbg_state;

    int checks = 0;
    int fails  = 0;
    logic [32:0] exp_q[$];
    logic [7:0]  mdl [32];

    rv32i_dmem_amo_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .dbg_state(dbg_state)
    );

    // Clock and reset-time defaults.
    always #5 clk = ~clk;

    // Wait for req_ready, queue the expected response, present the request for one accept edge.
    task automatic start_req(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL req_ready_wait: got %b, required 1", req_ready);
        end
        exp_q.push_back({exp_err, exp_rd});
        req_op = op; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Wait for rsp_valid after an accept edge, check latency and popped expectation.
    task automatic get_rsp(input int exp_lat, input string name);
        int lat = 0;
        logic [32:0] e;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 12);
        checks++;
        if (lat != exp_lat || rsp_valid !== 1'b1) begin
            fails++;
            $display("FAIL %s_latency: got %0d (valid=%b), required %0d", name, lat, rsp_valid, exp_lat);
        end
        if (rsp_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL %s_queue: response with no expected entry", name);
            end else begin
                e = exp_q.pop_front();
                if (rsp_rdata !== e[31:0] || rsp_err !== e[32]) begin
                    fails++;
                    $display("FAIL %s_data: got rdata=%h err=%b, required rdata=%h err=%b",
                             name, rsp_rdata, rsp_err, e[31:0], e[32]);
                end
            end
            if (rsp_ready === 1'b1) begin
                @(negedge clk);
                checks++;
                if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
                    fails++;
                    $display("FAIL %s_after_hs: got valid=%b ready=%b rdata=%h err=%b, required 0 1 0 0",
                             name, rsp_valid, req_ready, rsp_rdata, rsp_err);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
        req_op = 2'b00; req_funct3 = 3'b010; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0 || dbg_state !== 2'd0) begin
            fails++;
            $display("FAIL reset_values: got ready=%b valid=%b rdata=%h err=%b st=%0d, required 0 0 0 0 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err, dbg_state);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: got %b, required 1", req_ready);
        end
    endtask

    task automatic test_word();
        start_req(2'b01, 3'b010, 32'h10, 32'h12345678, 32'd0, 1'b0);
        get_rsp(2, "sw_10");
        start_req(2'b00, 3'b010, 32'h10, 32'd0, 32'h12345678, 1'b0);
        get_rsp(2, "lw_10");
    endtask

    task automatic test_byte();
        start_req(2'b01, 3'b000, 32'h11, 32'h000000AB, 32'd0, 1'b0);
        get_rsp(2, "sb_11");
        start_req(2'b00, 3'b000, 32'h11, 32'd0, 32'hFFFFFFAB, 1'b0);
        get_rsp(2, "lb_11");
        start_req(2'b00, 3'b100, 32'h11, 32'd0, 32'h000000AB, 1'b0);
        get_rsp(2, "lbu_11");
        start_req(2'b00, 3'b010, 32'h10, 32'd0, 32'h1234AB78, 1'b0);
        get_rsp(2, "lw_merged");
        start_req(2'b00, 3'b001, 32'h12, 32'd0, 32'h00001234, 1'b0);
        get_rsp(2, "lh_12");
    endtask

    task automatic test_amo();
        start_req(2'b01, 3'b010, 32'h20, 32'hFFFFFFFF, 32'd0, 1'b0);
        get_rsp(2, "sw_20");
        start_req(2'b10, 3'b010, 32'h20, 32'd2, 32'hFFFFFFFF, 1'b0);
        get_rsp(3, "amo_20");
        start_req(2'b00, 3'b010, 32'h20, 32'd0, 32'h00000001, 1'b0);
        get_rsp(2, "lw_20");
    endtask

    task automatic test_errors();
        start_req(2'b01, 3'b010, 32'h0, 32'hCAFEF00D, 32'd0, 1'b0);
        get_rsp(2, "sw_0");
        start_req(2'b00, 3'b010, 32'h02, 32'd0, 32'd0, 1'b1);
        get_rsp(2, "lw_misalign");
        start_req(2'b01, 3'b010, DEPTH * 4, 32'hDEADBEEF, 32'd0, 1'b1);
        get_rsp(2, "sw_range");
        start_req(2'b10, 3'b000, 32'h0, 32'd7, 32'd0, 1'b1);
        get_rsp(2, "amo_f3");
        start_req(2'b11, 3'b010, 32'h0, 32'd9, 32'd0, 1'b1);
        get_rsp(2, "op_rsvd");
        start_req(2'b01, 3'b100, 32'h0, 32'd1, 32'd0, 1'b1);
        get_rsp(2, "sbu_illegal");
        start_req(2'b00, 3'b101, 32'h01, 32'd0, 32'd0, 1'b1);
        get_rsp(2, "lhu_misalign");
        start_req(2'b00, 3'b010, 32'h0, 32'd0, 32'hCAFEF00D, 1'b0);
        get_rsp(2, "lw_0_unchanged");
    endtask

    task automatic test_backpressure();
        logic [31:0] rd0;
        logic        er0;
        rsp_ready = 1'b0;
        start_req(2'b00, 3'b010, 32'h10, 32'd0, 32'h1234AB78, 1'b0);
        get_rsp(2, "bp_lw");
        rd0 = rsp_rdata; er0 = rsp_err;
        exp_q.push_back({1'b0, 32'h00000001});
        req_op = 2'b00; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'd0; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== rd0 || rsp_err !== er0 || req_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold_%0d: got valid=%b rdata=%h err=%b ready=%b, required 1 %h %b 0",
                         i, rsp_valid, rsp_rdata, rsp_err, req_ready, rd0, er0);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || dbg_state !== 2'd0) begin
            fails++;
            $display("FAIL bp_after_hs: got ready=%b valid=%b st=%0d, required 1 0 0", req_ready, rsp_valid, dbg_state);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        get_rsp(2, "bp_held_lw");
    endtask

    task automatic test_reset_mid_amo();
        bit seen = 1'b0;
        start_req(2'b01, 3'b010, 32'h30, 32'd5, 32'd0, 1'b0);
        get_rsp(2, "sw_30");
        @(negedge clk);
        req_op = 2'b10; req_funct3 = 3'b010; req_addr = 32'h30; req_wdata = 32'd1; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (dbg_state !== 2'd2) begin
            fails++;
            $display("FAIL amo_wb_state: got %0d, required 2", dbg_state);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0 || dbg_state !== 2'd0) begin
            fails++;
            $display("FAIL mid_reset_outputs: got valid=%b rdata=%h err=%b st=%0d, required 0 0 0 0",
                     rsp_valid, rsp_rdata, rsp_err, dbg_state);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            fails++;
            $display("FAIL aborted_amo_rsp: got a response, required none");
        end
        start_req(2'b00, 3'b010, 32'h30, 32'd0, 32'd5, 1'b0);
        get_rsp(2, "lw_30_after_abort");
    endtask

    function automatic logic [31:0] mdl_load(input logic [2:0] f3, input int a);
        case (f3)
            3'b000:  return {{24{mdl[a][7]}}, mdl[a]};
            3'b100:  return {24'd0, mdl[a]};
            3'b001:  return {{16{mdl[a+1][7]}}, mdl[a+1], mdl[a]};
            3'b101:  return {16'd0, mdl[a+1], mdl[a]};
            default: return {mdl[a+3], mdl[a+2], mdl[a+1], mdl[a]};
        endcase
    endfunction

    task automatic test_random();
        logic [2:0]  ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [2:0]  f3;
        logic [31:0] wd;
        int a;
        int nb;
        for (int w = 0; w < 8; w++) begin
            wd = $urandom;
            for (int b = 0; b < 4; b++) mdl[w*4+b] = wd[8*b +: 8];
            start_req(2'b01, 3'b010, 32'h40 + w*4, wd, 32'd0, 1'b0);
            get_rsp(2, "rnd_init");
        end
        for (int k = 0; k < 30; k++) begin
            wd = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                f3 = 3'($urandom_range(0, 2));
                nb = 1 << f3;
                a  = $urandom_range(0, 31) & ~(nb - 1);
                for (int b = 0; b < nb; b++) mdl[a+b] = wd[8*b +: 8];
                start_req(2'b01, f3, 32'h40 + a, wd, 32'd0, 1'b0);
                get_rsp(2, "rnd_store");
            end else begin
                f3 = ld_f3[$urandom_range(0, 4)];
                nb = 1 << f3[1:0];
                a  = $urandom_range(0, 31) & ~(nb - 1);
                start_req(2'b00, f3, 32'h40 + a, wd, mdl_load(f3, a), 1'b0);
                get_rsp(2, "rnd_load");
            end
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_amo();
        test_errors();
        test_backpressure();
        test_reset_mid_amo();
        test_random();
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
